// File: rtl/bin_cntr.sv
// -----------------------------------------------------------------------------
// bin_cntr
//
// Free-running binary up-counter with a synchronous enable and a synchronous
// active-high reset. The count wraps modulo 2^WIDTH. Q comes straight from the
// count register, so there is no combinational path from any input to Q.
//
// Parameters:
//   WIDTH  counter width in bits (>= 1), default 8
//
// Ports:
//   clk    input               clock; all state changes on its rising edge
//   rst    input               synchronous active-high reset (highest priority)
//   en     input               count enable, active-high
//   Q      output [WIDTH-1:0]  current count, unsigned, registered
// -----------------------------------------------------------------------------
module bin_cntr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Reset is tested before en, so an unknown en while rst is high
    // can never reach the register.
    always_comb begin
        count_d = count_q;
        if (rst) begin
            count_d = '0;
        end else if (en) begin
            // Plain truncating add: the carry out is dropped, giving the wrap.
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign Q = count_q;

endmodule

// File: tb/tb_bin_cntr.sv
// -----------------------------------------------------------------------------
// tb_bin_cntr
//
// Directed bench for bin_cntr (WIDTH=8). The stimulus process drives rst/en on
// the falling edge and, just after the following rising edge, pushes the
// hand-computed expected count into a queue. A separate monitor pops one entry
// on each falling edge and compares it against Q.
// -----------------------------------------------------------------------------
module tb_bin_cntr;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] Q;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q[$];
    string            tag_q[$];

    bin_cntr #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .Q   (Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: the count is stable between rising edges, so compare at the
    // falling edge whatever expectation the last rising edge produced.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [WIDTH-1:0] e;
            string            t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (Q !== e) begin
                errors++;
                $display("FAIL %s: Q=%0d (0x%h) expected %0d (0x%h) at %0t",
                         t, Q, Q, e, e, $time);
            end
        end
    end

    // One clock of stimulus with the value Q must hold after that edge.
    task automatic step(input logic r, input logic e, input logic [WIDTH-1:0] exp_v,
                        input string tag);
        @(negedge clk);
        rst = r;
        en  = e;
        @(posedge clk);
        #1;
        exp_q.push_back(exp_v);
        tag_q.push_back(tag);
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b0;

        // Reset with en unknown, then held in reset while enabled.
        step(1'b1, 1'bx, 8'd0, "reset_en_x");
        step(1'b1, 1'b1, 8'd0, "reset_hold_en1");
        step(1'b1, 1'b1, 8'd0, "reset_hold_en1");

        // Enabled count 1..100.
        for (int i = 1; i <= 100; i++) step(1'b0, 1'b1, 8'(i), "count_up");

        // Hold at 100 for 100 edges.
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 8'd100, "hold");

        // Resume up to the terminal value 255 (155 edges).
        for (int i = 101; i <= 255; i++) step(1'b0, 1'b1, 8'(i), "resume");

        // Wrap from 255.
        step(1'b0, 1'b1, 8'd0, "wrap_to_0");
        step(1'b0, 1'b1, 8'd1, "wrap_then_1");

        // Alternating enable.
        step(1'b0, 1'b0, 8'd1, "alt_hold");
        step(1'b0, 1'b1, 8'd2, "alt_count");
        step(1'b0, 1'b0, 8'd2, "alt_hold");
        step(1'b0, 1'b1, 8'd3, "alt_count");

        // Climb to 0x37, then reset with en=1 and resume.
        for (int i = 4; i <= 8'h37; i++) step(1'b0, 1'b1, 8'(i), "to_0x37");
        step(1'b1, 1'b1, 8'd0, "reset_priority");
        step(1'b0, 1'b1, 8'd1, "resume_after_reset");
        step(1'b0, 1'b1, 8'd2, "resume_after_reset");

        // Give the monitor a bounded time to drain the queue.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0",
                     exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
